// File: rtl/adc_ddr3_capture_writer_if.sv
// ---------------------------------------------------------------------------
// adc_ddr3_capture_writer_if
// Avalon-MM style 256-bit write channel between the ADC capture writer and
// the DDR3 EMIF.
//   ready        : EMIF can accept a beat (= !waitrequest)
//   write        : beat valid / write request
//   addr         : 22-bit word address, meaningful on the first beat
//   write_data   : 256-bit beat data
//   byte_enable  : 32 byte lanes
//   burst_count  : beats in the burst
// master modport = capture writer, slave modport = EMIF side.
// ---------------------------------------------------------------------------
interface adc_ddr3_capture_writer_if;
   logic         ready;
   logic         write;
   logic [21:0]  addr;
   logic [255:0] write_data;
   logic [31:0]  byte_enable;
   logic [4:0]   burst_count;

   modport master (
      input  ready,
      output write, addr, write_data, byte_enable, burst_count
   );

   modport slave (
      output ready,
      input  write, addr, write_data, byte_enable, burst_count
   );
endinterface

// File: rtl/adc_ddr3_capture_writer.sv
// ---------------------------------------------------------------------------
// adc_ddr3_capture_writer
// Captures 14-bit ADC samples after a trigger, packs sixteen of them into
// each 256-bit word, buffers the words in a small FIFO and writes them to a
// contiguous DDR3 region as fixed-length bursts.
//
// Ports:
//   clk_200m       block clock
//   reset_n        asynchronous active-low reset
//   arm            one-cycle request to leave IDLE and wait for a trigger
//   capture_pulse  trigger, starts acquisition when armed
//   sample_valid   sample qualifier
//   sample_data    14-bit offset-binary ADC sample
//   ddr3_emif      write channel (master modport)
//   busy           high while ARMED / CAPTURE / DRAIN
//   done           one-cycle pulse with the final accepted beat
//   overflow       sticky FIFO overflow flag, cleared by arm
//
// Build option: define ADC_WR_TEST_PATTERN_EN to replace sample_data with an
// internal 14-bit counter (cleared by arm, advanced per valid sample).
// ---------------------------------------------------------------------------
module adc_ddr3_capture_writer #(
   parameter int          BURST_LEN  = 8,
   parameter int          NUM_BURSTS = 1024,
   parameter logic [21:0] BASE_ADDR  = 22'h000000,
   parameter int          FIFO_DEPTH = 32
) (
   input  logic                              clk_200m,
   input  logic                              reset_n,
   input  logic                              arm,
   input  logic                              capture_pulse,
   input  logic                              sample_valid,
   input  logic [13:0]                       sample_data,
   adc_ddr3_capture_writer_if.master         ddr3_emif,
   output logic                              busy,
   output logic                              done,
   output logic                              overflow
);

   localparam int TOTAL_WORDS = NUM_BURSTS * BURST_LEN;
   localparam int WCW         = $clog2(TOTAL_WORDS + 1);
   localparam int BCW         = $clog2(NUM_BURSTS + 1);
   localparam int AW          = $clog2(FIFO_DEPTH);

   localparam logic [WCW-1:0] LAST_WORD   = WCW'(TOTAL_WORDS - 1);
   localparam logic [BCW-1:0] NB_C        = BCW'(NUM_BURSTS);
   localparam logic [3:0]     LAST_BEAT   = 4'(BURST_LEN - 1);
   localparam logic [AW:0]    FULL_LVL    = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]    BURST_LVL   = (AW+1)'(BURST_LEN);

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DRAIN} state_t;

   state_t             state_reg, state_next;

   logic [3:0]         pack_idx_reg;
   logic [15:0]        lane_reg [15];
   logic [255:0]       word_in;
   logic [WCW-1:0]     word_cnt_reg;

   logic [255:0]       fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]        level_reg;

   logic               burst_active_reg;
   logic [3:0]         beat_cnt_reg;
   logic [BCW-1:0]     burst_cnt_reg;
   logic [21:0]        addr_reg;
   logic               overflow_reg;

   logic [13:0]        sample_sel;
   logic               arm_go, pack_fire, word_done, last_word;
   logic               accept, last_beat, done_int;
   logic               fifo_empty, fifo_full, push, pop, drop, burst_start;

   // ------------------------------------------------------------------
   // Sample source
   // ------------------------------------------------------------------
`ifdef ADC_WR_TEST_PATTERN_EN
   logic [13:0] tp_cnt_reg;
   logic        unused_sample;

   assign unused_sample = ^sample_data;

   always_ff @(posedge clk_200m or negedge reset_n) begin
      if (!reset_n)
         tp_cnt_reg <= '0;
      else if (arm_go)
         tp_cnt_reg <= '0;
      else if (state_reg == ST_CAPTURE && sample_valid)
         tp_cnt_reg <= tp_cnt_reg + 14'd1;
   end

   assign sample_sel = tp_cnt_reg;
`else
   assign sample_sel = sample_data;
`endif

   // ------------------------------------------------------------------
   // Control terms
   // ------------------------------------------------------------------
   assign arm_go     = (state_reg == ST_IDLE) && arm;
   assign pack_fire  = (state_reg == ST_CAPTURE) && sample_valid;
   assign word_done  = pack_fire && (pack_idx_reg == 4'd15);
   assign last_word  = word_done && (word_cnt_reg == LAST_WORD);

   assign accept     = burst_active_reg && ddr3_emif.ready;
   assign last_beat  = accept && (beat_cnt_reg == LAST_BEAT);
   // burst_cnt_reg counts bursts started, so NB_C marks the final burst.
   assign done_int   = last_beat && (state_reg == ST_DRAIN) && (burst_cnt_reg == NB_C);

   assign fifo_empty = (level_reg == '0);
   assign fifo_full  = (level_reg == FULL_LVL);
   // Beats past the end of the FIFO contents are zero fill and pop nothing.
   assign pop        = accept && !fifo_empty;
   // A full FIFO still takes a word if a pop frees a slot in the same cycle.
   assign push       = word_done && (!fifo_full || pop);
   assign drop       = word_done && !push;

   // In DRAIN every word has been produced, so a burst may start with fewer
   // than BURST_LEN words left (dropped words) and zero-fill the remainder.
   assign burst_start = !burst_active_reg && (burst_cnt_reg != NB_C) &&
                        (((state_reg == ST_CAPTURE) && (level_reg >= BURST_LVL)) ||
                         (state_reg == ST_DRAIN));

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk_200m or negedge reset_n) begin
      if (!reset_n)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (arm)           state_next = ST_ARMED;
         ST_ARMED:   if (capture_pulse) state_next = ST_CAPTURE;
         ST_CAPTURE: if (last_word)     state_next = ST_DRAIN;
         ST_DRAIN:   if (done_int)      state_next = ST_IDLE;
         default:                       state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Packer: lanes 0..14 are held in registers, lane 15 is taken straight
   // from the 16th sample so the word is pushed in that same cycle.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_200m or negedge reset_n) begin
      if (!reset_n) begin
         pack_idx_reg <= '0;
         word_cnt_reg <= '0;
      end else if (arm_go) begin
         pack_idx_reg <= '0;
         word_cnt_reg <= '0;
      end else if (pack_fire) begin
         pack_idx_reg <= pack_idx_reg + 4'd1;
         if (word_done)
            word_cnt_reg <= word_cnt_reg + 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < 15; gi++) begin : g_lane
         always_ff @(posedge clk_200m or negedge reset_n) begin
            if (!reset_n)
               lane_reg[gi] <= '0;
            else if (pack_fire && pack_idx_reg == 4'(gi))
               lane_reg[gi] <= {2'b00, sample_sel};
         end
         assign word_in[16*gi +: 16] = lane_reg[gi];
      end
   endgenerate

   assign word_in[255:240] = {2'b00, sample_sel};

   // ------------------------------------------------------------------
   // First-word-fall-through FIFO; the head entry drives the beat data.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_200m) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= word_in;
   end

   always_ff @(posedge clk_200m or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else if (arm_go) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase
      end
   end

   always_ff @(posedge clk_200m or negedge reset_n) begin
      if (!reset_n)
         overflow_reg <= 1'b0;
      else if (arm_go)
         overflow_reg <= 1'b0;
      else if (drop)
         overflow_reg <= 1'b1;
   end

   // ------------------------------------------------------------------
   // Burst engine
   // ------------------------------------------------------------------
   always_ff @(posedge clk_200m or negedge reset_n) begin
      if (!reset_n) begin
         burst_active_reg <= 1'b0;
         beat_cnt_reg     <= '0;
         burst_cnt_reg    <= '0;
         addr_reg         <= BASE_ADDR;
      end else if (arm_go) begin
         burst_active_reg <= 1'b0;
         beat_cnt_reg     <= '0;
         burst_cnt_reg    <= '0;
         addr_reg         <= BASE_ADDR;
      end else if (burst_active_reg) begin
         if (accept) begin
            if (beat_cnt_reg == LAST_BEAT) begin
               burst_active_reg <= 1'b0;
               beat_cnt_reg     <= '0;
               addr_reg         <= addr_reg + 22'(BURST_LEN);
            end else begin
               beat_cnt_reg <= beat_cnt_reg + 4'd1;
            end
         end
      end else if (burst_start) begin
         burst_active_reg <= 1'b1;
         burst_cnt_reg    <= burst_cnt_reg + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Outputs: everything on the channel is zero outside a burst.
   // ------------------------------------------------------------------
   assign ddr3_emif.write       = burst_active_reg;
   assign ddr3_emif.addr        = burst_active_reg ? addr_reg : '0;
   assign ddr3_emif.write_data  = (burst_active_reg && !fifo_empty) ? fifo_mem[rd_ptr_reg] : '0;
   assign ddr3_emif.byte_enable = {32{burst_active_reg}};
   assign ddr3_emif.burst_count = burst_active_reg ? 5'(BURST_LEN) : 5'd0;

   assign busy     = (state_reg != ST_IDLE);
   assign done     = done_int;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_adc_ddr3_capture_writer.sv
// ---------------------------------------------------------------------------
// tb_adc_ddr3_capture_writer
// Directed bench for adc_ddr3_capture_writer (BURST_LEN 8, NUM_BURSTS 5,
// FIFO_DEPTH 32). Hand sequences cover reset, trigger-without-arm,
// trigger-with-arm, and reset in the middle of a burst; a table of capture
// scenarios covers ready patterns, sample patterns and FIFO overflow.
// ---------------------------------------------------------------------------
module tb_adc_ddr3_capture_writer;

   localparam int          BL   = 8;
   localparam int          NB   = 5;
   localparam int          FD   = 32;
   localparam int          NW   = BL * NB;
   localparam int          NS   = NW * 16;
   localparam logic [21:0] BASE = 22'h000000;

   logic        clk_200m      = 1'b0;
   logic        reset_n       = 1'b0;
   logic        arm           = 1'b0;
   logic        capture_pulse = 1'b0;
   logic        sample_valid  = 1'b0;
   logic [13:0] sample_data   = '0;
   logic        busy, done, overflow;

   adc_ddr3_capture_writer_if ddr3_emif ();

   adc_ddr3_capture_writer #(
      .BURST_LEN  (BL),
      .NUM_BURSTS (NB),
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk_200m      (clk_200m),
      .reset_n       (reset_n),
      .arm           (arm),
      .capture_pulse (capture_pulse),
      .sample_valid  (sample_valid),
      .sample_data   (sample_data),
      .ddr3_emif     (ddr3_emif.master),
      .busy          (busy),
      .done          (done),
      .overflow      (overflow)
   );

   always #5 clk_200m = ~clk_200m;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Ready generator: 0 = always ready, 1 = toggling, 2 = stalled for
   // 2000 cycles from stall_start, then ready.
   // ------------------------------------------------------------------
   int cyc         = 0;
   int ready_mode  = 0;
   int stall_start = 0;

   always @(posedge clk_200m) begin
      #1;
      cyc++;
      case (ready_mode)
         1:       ddr3_emif.ready = cyc[0];
         2:       ddr3_emif.ready = ((cyc - stall_start) >= 2000);
         default: ddr3_emif.ready = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------
   // Monitor: records accepted beats, checks hold-while-stalled behaviour.
   // ------------------------------------------------------------------
   logic [255:0] beat_data_q [$];
   logic [21:0]  beat_addr_q [$];
   int           ctl_err  = 0;
   int           stab_err = 0;
   int           done_cnt = 0;
   int           done_beat = 0;
   logic         prev_w = 1'b0, prev_r = 1'b0;
   logic [255:0] prev_d = '0;
   logic [21:0]  prev_a = '0;
   logic [4:0]   prev_bc = '0;

   always @(negedge clk_200m) begin
      if (reset_n) begin
         if (prev_w && !prev_r &&
             (!ddr3_emif.write || ddr3_emif.write_data !== prev_d ||
              ddr3_emif.addr !== prev_a || ddr3_emif.burst_count !== prev_bc))
            stab_err++;
         if (ddr3_emif.write && ddr3_emif.ready) begin
            beat_data_q.push_back(ddr3_emif.write_data);
            beat_addr_q.push_back(ddr3_emif.addr);
            if (ddr3_emif.burst_count !== 5'(BL) || ddr3_emif.byte_enable !== '1)
               ctl_err++;
         end
         if (done) begin
            done_cnt++;
            done_beat = beat_data_q.size();
         end
         prev_w  = ddr3_emif.write;
         prev_r  = ddr3_emif.ready;
         prev_d  = ddr3_emif.write_data;
         prev_a  = ddr3_emif.addr;
         prev_bc = ddr3_emif.burst_count;
      end else begin
         prev_w = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk_200m);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_write"}, 256'(ddr3_emif.write), 256'(0));
      check({tag, "_addr"},  256'(ddr3_emif.addr), 256'(0));
      check({tag, "_data"},  ddr3_emif.write_data, 256'(0));
      check({tag, "_be"},    256'(ddr3_emif.byte_enable), 256'(0));
      check({tag, "_bc"},    256'(ddr3_emif.burst_count), 256'(0));
      check({tag, "_busy"},  256'(busy), 256'(0));
      check({tag, "_done"},  256'(done), 256'(0));
      check({tag, "_ovf"},   256'(overflow), 256'(0));
   endtask

   // ------------------------------------------------------------------
   // Scenario table
   // ready_mode: see generator. valid_mode: 0 every cycle, 1 every other.
   // data_mode: 0 ramp (sample index), 1 constant 3FFF, 2 random.
   // exp_kept: words that reach DDR3 with real data; the rest are zero.
   // ------------------------------------------------------------------
   typedef struct {
      int   ready_mode;
      int   valid_mode;
      int   data_mode;
      int   exp_kept;
      logic exp_ovf;
   } vec_t;

   vec_t         vecs [5];
   logic [255:0] exp_w [NW];

   task automatic run_scenario(input int v);
      int           beat_base, done_base, ctl_base, stab_base, i, t, n;
      logic [13:0]  s;
      logic [255:0] exp_d;
      logic [21:0]  exp_a;
      bit           finished;

      beat_base = beat_data_q.size();
      done_base = done_cnt;
      ctl_base  = ctl_err;
      stab_base = stab_err;
      ready_mode = vecs[v].ready_mode;

      arm = 1'b1;
      tick();
      arm = 1'b0;
      check($sformatf("v%0d_busy_after_arm", v), 256'(busy), 256'(1));
      check($sformatf("v%0d_ovf_clear_on_arm", v), 256'(overflow), 256'(0));

      tick();
      capture_pulse = 1'b1;
      stall_start   = cyc;
      tick();
      capture_pulse = 1'b0;

      // 16 extra samples past the last word must be ignored.
      i = 0;
      t = 0;
      while (i < NS + 16) begin
         sample_valid = (vecs[v].valid_mode == 0) || ((t % 2) == 0);
         if (sample_valid) begin
            case (vecs[v].data_mode)
               0:       s = 14'(i);
               1:       s = 14'h3FFF;
               default: s = 14'($urandom);
            endcase
            sample_data = s;
            if (i < NS)
               exp_w[i / 16][16 * (i % 16) +: 16] = {2'b00, s};
            i++;
         end
         tick();
         t++;
      end
      sample_valid = 1'b0;

      finished = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         if (!busy) begin
            finished = 1'b1;
            break;
         end
         tick();
      end
      check($sformatf("v%0d_finished", v), 256'(finished), 256'(1));

      n = beat_data_q.size() - beat_base;
      check($sformatf("v%0d_beats", v), 256'(n), 256'(NW));
      for (int k = 0; k < NW && k < n; k++) begin
         exp_d = (k < vecs[v].exp_kept) ? exp_w[k] : '0;
         exp_a = BASE + 22'((k / BL) * BL);
         check($sformatf("v%0d_data%0d", v, k), beat_data_q[beat_base + k], exp_d);
         check($sformatf("v%0d_addr%0d", v, k), 256'(beat_addr_q[beat_base + k]), 256'(exp_a));
      end
      check($sformatf("v%0d_ctl", v), 256'(ctl_err - ctl_base), 256'(0));
      check($sformatf("v%0d_hold", v), 256'(stab_err - stab_base), 256'(0));
      check($sformatf("v%0d_done_cnt", v), 256'(done_cnt - done_base), 256'(1));
      check($sformatf("v%0d_done_beat", v), 256'(done_beat - beat_base), 256'(NW));
      check($sformatf("v%0d_ovf", v), 256'(overflow), 256'(vecs[v].exp_ovf));
      check($sformatf("v%0d_write_idle", v), 256'(ddr3_emif.write), 256'(0));
      $display("scenario %0d: ready_mode=%0d valid_mode=%0d data_mode=%0d beats=%0d overflow=%0b",
               v, vecs[v].ready_mode, vecs[v].valid_mode, vecs[v].data_mode, n, overflow);
   endtask

   initial begin
      int  base;
      bit  hit;

      vecs[0] = '{0, 0, 0, NW, 1'b0};
      vecs[1] = '{1, 0, 0, NW, 1'b0};
      vecs[2] = '{2, 0, 0, FD, 1'b1};
      vecs[3] = '{0, 1, 1, NW, 1'b0};
      vecs[4] = '{1, 1, 2, NW, 1'b0};

      ddr3_emif.ready = 1'b1;

      // Reset state.
      repeat (4) tick();
      check_all_zero("reset");
      reset_n = 1'b1;
      tick();

      // Trigger while IDLE is ignored.
      base = beat_data_q.size();
      capture_pulse = 1'b1;
      tick();
      capture_pulse = 1'b0;
      sample_valid  = 1'b1;
      repeat (40) tick();
      sample_valid  = 1'b0;
      check("idle_pulse_busy", 256'(busy), 256'(0));
      check("idle_pulse_beats", 256'(beat_data_q.size() - base), 256'(0));
      $display("seq idle_pulse: busy=%0b beats=%0d", busy, beat_data_q.size() - base);

      // Trigger in the same cycle as arm is ignored; samples in ARMED too.
      arm = 1'b1;
      capture_pulse = 1'b1;
      tick();
      arm = 1'b0;
      capture_pulse = 1'b0;
      sample_valid  = 1'b1;
      repeat (300) tick();
      sample_valid  = 1'b0;
      check("armed_busy", 256'(busy), 256'(1));
      check("armed_beats", 256'(beat_data_q.size() - base), 256'(0));
      $display("seq arm_with_pulse: busy=%0b beats=%0d", busy, beat_data_q.size() - base);

      // Real trigger, then asynchronous reset during beat 3 of burst 0.
      capture_pulse = 1'b1;
      tick();
      capture_pulse = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         sample_valid = 1'b1;
         sample_data  = 14'(c);
         tick();
         if (beat_data_q.size() - base >= 3) begin
            hit = 1'b1;
            break;
         end
      end
      sample_valid = 1'b0;
      check("midburst_reached", 256'(hit), 256'(1));
      check("midburst_write", 256'(ddr3_emif.write), 256'(1));
      #2;
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      $display("seq midburst_reset: write=%0b busy=%0b", ddr3_emif.write, busy);
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      for (int v = 0; v < 5; v++)
         run_scenario(v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
